// File: rtl/core_ctrl_pkg.sv
// Shared types and constants for the accumulator-core instruction-cycle sequencer.
package core_ctrl_pkg;

    localparam int PC_W_DEFAULT = 11;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EXEC  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [3:0] Q1 = 4'b0001;
    localparam logic [3:0] Q2 = 4'b0010;
    localparam logic [3:0] Q3 = 4'b0100;
    localparam logic [3:0] Q4 = 4'b1000;

endpackage

// File: rtl/instr_cycle_ctrl_phase_ring.sv
// One-hot Q1..Q4 phase rotator; advances only while run is high so a stalled
// cycle resumes on the exact phase it stopped at.
module phase_ring
    import core_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_i,
    output logic [3:0] phase_o
);

    logic [3:0] phase_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            phase_q <= Q1;
        end else if (run_i) begin
            phase_q <= {phase_q[2:0], phase_q[3]};
        end
    end

    assign phase_o = phase_q;

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle sequencer: phase strobes, program counter, IR load,
// W/F write-enable gating and pipeline fill/flush control.
module instr_cycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int              PC_W      = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            is_write,
    input  logic            dest_d,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            skip_req,
    output logic [3:0]      phase,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    output logic            nop_out,
    output logic            w_we,
    output logic            f_we,
    output logic [15:0]     retired
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [3:0]      phaseRaw;
    logic            atQ4;
    logic            inExec;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     retired_q, retired_d;

    phase_ring uPhaseRing (
        .clk_i   (clk),
        .rst_i   (reset),
        .run_i   (run),
        .phase_o (phaseRaw)
    );

    assign atQ4   = run & phaseRaw[3];
    assign inExec = (state_q == EXEC);

    // Every sequencing decision is made on the Q4 clock and becomes visible at Q1.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        if (atQ4) begin
            pc_d = pc_q + PC_ONE;
            case (state_q)
                FILL, FLUSH: state_d = EXEC;
                EXEC: begin
                    retired_d = retired_q + 16'd1;
                    if (jump) begin
                        pc_d    = jump_target;
                        state_d = FLUSH;
                    end else if (skip_req) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = EXEC;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FILL;
            pc_q      <= RESET_VEC;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

    assign phase   = phaseRaw & {4{run}};
    assign pc      = pc_q;
    assign retired = retired_q;
    assign ir_load = atQ4;
    assign nop_out = ~inExec;
    assign w_we    = atQ4 & inExec & is_write & ~dest_d;
    assign f_we    = atQ4 & inExec & is_write & dest_d;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Scoreboard bench for instr_cycle_ctrl: a cycle model pushes expected outputs
// as each stimulus is driven and they are popped and compared against the DUT.
module tb_instr_cycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        isWrite;
    logic        destD;
    logic        jump;
    logic [10:0] jumpTarget;
    logic        skipReq;
    logic [3:0]  phase;
    logic [10:0] pc;
    logic        irLoad;
    logic        nopOut;
    logic        wWe;
    logic        fWe;
    logic [15:0] retired;

    typedef struct packed {
        logic [3:0]  phase;
        logic [10:0] pc;
        logic        irLoad;
        logic        nop;
        logic        wWe;
        logic        fWe;
        logic [15:0] retired;
    } expT;

    expT sbQ[$];

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: phase index 0..3, state 0=fill 1=exec 2=flush.
    int          mPhase;
    int          mState;
    logic [10:0] mPc;
    logic [15:0] mRetired;

    instr_cycle_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .is_write    (isWrite),
        .dest_d      (destD),
        .jump        (jump),
        .jump_target (jumpTarget),
        .skip_req    (skipReq),
        .phase       (phase),
        .pc          (pc),
        .ir_load     (irLoad),
        .nop_out     (nopOut),
        .w_we        (wWe),
        .f_we        (fWe),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase   = 0;
        mState   = 0;
        mPc      = 11'h000;
        mRetired = 16'h0000;
    endtask

    task automatic applyStimulus(input logic r, input logic iw, input logic dd, input logic j,
                                 input logic [10:0] t, input logic s);
        expT  e;
        logic q4;
        logic ex;
        run        = r;
        isWrite    = iw;
        destD      = dd;
        jump       = j;
        jumpTarget = t;
        skipReq    = s;
        q4 = r && (mPhase == 3);
        ex = (mState == 1);
        e.phase   = r ? 4'(1 << mPhase) : 4'b0000;
        e.pc      = mPc;
        e.irLoad  = q4;
        e.nop     = !ex;
        e.wWe     = q4 && ex && iw && !dd;
        e.fWe     = q4 && ex && iw && dd;
        e.retired = mRetired;
        sbQ.push_back(e);
        if (r) begin
            if (q4) begin
                if (ex) begin
                    mRetired = mRetired + 16'd1;
                    if (j) begin
                        mPc    = t;
                        mState = 2;
                    end else begin
                        mPc    = mPc + 11'd1;
                        mState = s ? 2 : 1;
                    end
                end else begin
                    mPc    = mPc + 11'd1;
                    mState = 1;
                end
            end
            mPhase = (mPhase + 1) % 4;
        end
    endtask

    task automatic checkCycle();
        expT e;
        checkOutput("sb_depth", sbQ.size(), 1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("phase", phase, e.phase);
            checkOutput("pc", pc, e.pc);
            checkOutput("ir_load", irLoad, e.irLoad);
            checkOutput("nop_out", nopOut, e.nop);
            checkOutput("w_we", wWe, e.wWe);
            checkOutput("f_we", fWe, e.fWe);
            checkOutput("retired", retired, e.retired);
        end
    endtask

    task automatic runCycle(input logic r, input logic iw, input logic dd, input logic j,
                            input logic [10:0] t, input logic s);
        applyStimulus(r, iw, dd, j, t, s);
        #1;
        checkCycle();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) runCycle(1'b1, 1'b0, 1'b0, 1'b0, 11'h000, 1'b0);
    endtask

    task automatic advanceTo(input int p);
        for (int i = 0; i < 4 && mPhase != p; i++) idle(1);
    endtask

    // Reset raised between clock edges; outputs must change before any posedge.
    task automatic pulseReset();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_phase", phase, run ? 4'b0001 : 4'b0000);
        checkOutput("rst_pc", pc, 11'h000);
        checkOutput("rst_retired", retired, 16'h0000);
        checkOutput("rst_nop", nopOut, 1'b1);
        checkOutput("rst_ir_load", irLoad, 1'b0);
        checkOutput("rst_w_we", wWe, 1'b0);
        checkOutput("rst_f_we", fWe, 1'b0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        run        = 1'b0;
        isWrite    = 1'b0;
        destD      = 1'b0;
        jump       = 1'b0;
        jumpTarget = 11'h000;
        skipReq    = 1'b0;
        modelReset();
        #1;
        checkOutput("init_phase", phase, 4'b0000);
        checkOutput("init_pc", pc, 11'h000);
        checkOutput("init_nop", nopOut, 1'b1);
        checkOutput("init_retired", retired, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        idle(8);

        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b1, 1'b0, 1'b0, 11'h000, 1'b0);
        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b1, 1'b1, 1'b0, 11'h000, 1'b0);

        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b1, 1'b0, 1'b1, 11'h123, 1'b0);
        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b1, 1'b1, 1'b0, 11'h000, 1'b0);
        idle(4);

        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0, 1'b0, 1'b1, 11'h055, 1'b1);
        idle(8);

        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0, 1'b0, 1'b0, 11'h3AA, 1'b1);
        idle(8);

        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0, 1'b0, 1'b1, 11'h7FE, 1'b0);
        idle(12);

        advanceTo(1);
        idle(1);
        for (int i = 0; i < 5; i++)
            runCycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 11'($urandom), 1'($urandom_range(0, 1)));
        idle(6);

        advanceTo(2);
        pulseReset();
        idle(8);

        for (int i = 0; i < 80; i++)
            runCycle(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 5) == 0), 11'($urandom), 1'($urandom_range(0, 4) == 0));

        checkOutput("sb_drain", sbQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
